uart_tick_gen: RTL and testbench
================================

# uart_tick_gen

Parametrised successor to the fixed UART clock generator. It derives a sample-rate tick and a bit-rate (baud) tick from `sys_clk` using a runtime-programmable divisor and a parametrised oversampling ratio. It also provides the legacy 50%-duty toggled `smp_clk`/`bot_clk` outputs. Adds enable, phase resync (RX start-bit alignment) and glitch-free divisor updates at bit boundaries. It sits between the system clock and the UART TX/RX engines.

## Interface
- `DIV_W`, 16: width of the divisor and of the sample counter.
- `OVS`, 16: samples per bit. Legal values are 2..256.
- `IDX_W`, `$clog2(OVS)`: width of `smp_idx`.
- `DEFAULT_DIV`, 326: `sys_clk` cycles per sample tick after reset. Must be ≥2.

Ports:
- `sys_clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable.
- `resync`  in  1  single-cycle request to restart the sample and bit phase.
- `div_wr`  in  1  divisor write strobe.
- `div_in`  in  DIV_W  new divisor value (sys_clk cycles per sample).
- `div_busy`  out  1  a divisor write is pending; further writes are ignored.
- `smp_tick`  out  1  one-cycle pulse at the sample rate.
- `bot_tick`  out  1  one-cycle pulse at the bit rate; coincides with the last `smp_tick` of each bit.
- `smp_idx`  out  IDX_W  sample index within the current bit, 0..OVS-1.
- `smp_clk`  out  1  toggles on every `smp_tick`.
- `bot_clk`  out  1  toggles on every `bot_tick`.

## Operation
- **State:**
  - `scnt` [DIV_W]: sample counter.
  - `sidx` [IDX_W]: drives `smp_idx`.
  - `div_act`: active divisor.
  - `div_pend`: pending divisor.
  - `div_busy`.
- **Reset** (asynchronous, while `reset`=0):
  - `scnt`=0, `sidx`=0, `div_act`=DEFAULT_DIV, `div_pend`=DEFAULT_DIV.
  - `div_busy`=0, `smp_tick`=0, `bot_tick`=0, `smp_clk`=0, `bot_clk`=0.
- **Edge priority:** reset, then resync, then en. All outputs are registered.
- **resync=1:**
  - `scnt`←0, `sidx`←0, ticks←0.
  - `smp_clk`/`bot_clk` hold.
  - A pending divisor is applied on this edge.
- **en=0 (no resync):**
  - Counters and clocks hold; ticks←0.
  - A pending divisor is applied on this edge.
- **en=1, counting:**
  - `scnt`≠div_act−1: `scnt`←`scnt`+1, `smp_tick`←0, `bot_tick`←0.
  - `scnt`=div_act−1: `scnt`←0, `smp_tick`←1, `smp_clk`←~`smp_clk`.
  - On that same edge, if `sidx`=OVS−1: `sidx`←0, `bot_tick`←1, `bot_clk`←~`bot_clk`, and a pending divisor is applied. Otherwise `sidx`←`sidx`+1.
- **Divisor write:**
  - `div_wr`=1 with `div_busy`=0: `div_pend`←max(`div_in`,2) and `div_busy`←1.
  - Values 0 and 1 are clamped to 2.
  - `div_wr` while `div_busy`=1 is ignored and `div_pend` is unchanged.
- **Apply** (bot_tick edge, en=0 edge, or resync edge, whenever `div_busy`=1):
  - `div_act`←`div_pend`, `div_busy`←0.
  - Bit periods are never mixed between two divisors.
- **Write on an apply edge:** `div_busy` is still 1 on that edge, so the write is ignored. Software must wait for `div_busy`=0.
- **Width rule:** `scnt` compare is against `div_act`−1 in DIV_W bits; `div_act` is never below 2.

## Timing
- Sample period is `div_act` cycles; bit period is `div_act`·OVS cycles.
- `smp_clk` period is 2·`div_act`; `bot_clk` period is 2·`div_act`·OVS.
- From reset release with en=1, the first `smp_tick` is high after rising edge `div_act`. The first `bot_tick` is high after edge `div_act`·OVS.
- `smp_idx` reads k during the sample interval following the k-th tick of the bit.
- After a resync edge R, the next `smp_tick` is high after edge R+`div_act`.
- `div_busy` rises the edge after `div_wr` is sampled. It falls on the apply edge.
- The new divisor governs the count starting on the edge after the apply edge.
- Asserting reset mid-operation clears all outputs immediately, without waiting for a clock edge.

## Test plan
- **Free run** (DEFAULT_DIV=4, OVS=4, en=1 from release): `smp_tick` at edges 4, 8, 12, 16; `bot_tick` only at 16, 32; `smp_clk` 1 after edge 4 and 0 after edge 8; `bot_clk` 1 after 16.
- **Divisor update:** `div_wr`, `div_in`=6 sampled at edge 5 → `div_busy` 1 after edge 5, 0 after edge 16. Next `smp_tick` at 22, 28; next `bot_tick` at 40.
- **Clamp and busy:** write `div_in`=0, then `div_in`=9 while busy → after apply, `smp_tick` spacing is 2 cycles; the value 9 never takes effect.
- **Resync:** resync at edge 10 in the free-run setup → `smp_idx`=0, next `smp_tick` at 14, `bot_tick` at 26. Clocks are not toggled at edge 10.
- **Enable hold:** `en`=0 for edges 6–9 → `scnt`/`smp_idx` frozen, no ticks, a pending divisor is applied at edge 6; counting resumes at edge 10.
- **Async reset mid-bit:** drop `reset` between edges → all outputs 0 and `div_busy`=0 before the next edge; after release, behaviour matches the free-run case.

Source files
------------

// File: rtl/uart_tick_gen.sv
// Sample-rate and bit-rate tick generator with a runtime divisor and legacy toggled clocks.
// Divisor writes are staged and only take effect at a bit boundary, an en=0 edge or a resync.
module uart_tick_gen #(
  parameter int DIV_W       = 16,
  parameter int OVS         = 16,
  parameter int IDX_W       = $clog2(OVS),
  parameter int DEFAULT_DIV = 326
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             en,
  input  logic             resync,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_in,
  output logic             div_busy,
  output logic             smp_tick,
  output logic             bot_tick,
  output logic [IDX_W-1:0] smp_idx,
  output logic             smp_clk,
  output logic             bot_clk
);

  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVS - 1);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    if (d < DIV_W'(2)) begin
      clamp_div = DIV_W'(2);
    end else begin
      clamp_div = d;
    end
  endfunction

  logic [DIV_W-1:0] r_scnt;
  logic [IDX_W-1:0] r_sidx;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] r_div_pend;
  logic             r_div_busy;
  logic             r_smp_tick;
  logic             r_bot_tick;
  logic             r_smp_clk;
  logic             r_bot_clk;

  logic w_smp_end;
  logic w_bit_end;
  logic w_apply;
  logic w_accept;

  // Sample/bit boundary detection and divisor apply/accept decisions
  always_comb begin
    w_smp_end = (r_scnt == (r_div_act - DIV_W'(1)));
    w_bit_end = w_smp_end && (r_sidx == IDX_LAST);
    if (resync || !en) begin
      w_apply = r_div_busy;
    end else begin
      w_apply = r_div_busy && w_bit_end;
    end
    w_accept = div_wr && !r_div_busy;
  end

  // Sample and bit counters, tick pulses and toggled clocks
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_scnt     <= '0;
      r_sidx     <= '0;
      r_smp_tick <= 1'b0;
      r_bot_tick <= 1'b0;
      r_smp_clk  <= 1'b0;
      r_bot_clk  <= 1'b0;
    end else if (resync) begin
      r_scnt     <= '0;
      r_sidx     <= '0;
      r_smp_tick <= 1'b0;
      r_bot_tick <= 1'b0;
    end else if (!en) begin
      r_smp_tick <= 1'b0;
      r_bot_tick <= 1'b0;
    end else if (w_smp_end) begin
      r_scnt     <= '0;
      r_smp_tick <= 1'b1;
      r_smp_clk  <= ~r_smp_clk;
      if (r_sidx == IDX_LAST) begin
        r_sidx     <= '0;
        r_bot_tick <= 1'b1;
        r_bot_clk  <= ~r_bot_clk;
      end else begin
        r_sidx     <= r_sidx + IDX_W'(1);
        r_bot_tick <= 1'b0;
      end
    end else begin
      r_scnt     <= r_scnt + DIV_W'(1);
      r_smp_tick <= 1'b0;
      r_bot_tick <= 1'b0;
    end
  end

  // Divisor staging: apply and accept are mutually exclusive through r_div_busy
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_div_act  <= DIV_RST;
      r_div_pend <= DIV_RST;
      r_div_busy <= 1'b0;
    end else if (w_apply) begin
      r_div_act  <= r_div_pend;
      r_div_busy <= 1'b0;
    end else if (w_accept) begin
      r_div_pend <= clamp_div(div_in);
      r_div_busy <= 1'b1;
    end
  end

  assign div_busy = r_div_busy;
  assign smp_tick = r_smp_tick;
  assign bot_tick = r_bot_tick;
  assign smp_idx  = r_sidx;
  assign smp_clk  = r_smp_clk;
  assign bot_clk  = r_bot_clk;

endmodule

// File: tb/tb_uart_tick_gen.sv
// Scoreboard bench for uart_tick_gen: a cycle-level arithmetic model queues expected outputs
// per edge, and an independent monitor pops and compares them after every rising edge.
module tb_uart_tick_gen;
  localparam int DIV_W   = 16;
  localparam int OVS     = 4;
  localparam int IDX_W   = 2;
  localparam int DEF_DIV = 4;

  logic             sys_clk = 1'b0;
  logic             reset   = 1'b0;
  logic             en      = 1'b0;
  logic             resync  = 1'b0;
  logic             div_wr  = 1'b0;
  logic [DIV_W-1:0] div_in  = '0;
  logic             div_busy, smp_tick, bot_tick, smp_clk, bot_clk;
  logic [IDX_W-1:0] smp_idx;

  uart_tick_gen #(
    .DIV_W(DIV_W), .OVS(OVS), .IDX_W(IDX_W), .DEFAULT_DIV(DEF_DIV)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .en(en), .resync(resync),
    .div_wr(div_wr), .div_in(div_in), .div_busy(div_busy),
    .smp_tick(smp_tick), .bot_tick(bot_tick), .smp_idx(smp_idx),
    .smp_clk(smp_clk), .bot_clk(bot_clk)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int smp; int bot; int busy; int idx; int sclk; int bclk;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   dir_phase = 1'b0;
  int   dir_smp_edges[8] = '{4, 8, 12, 16, 22, 28, 34, 40};

  // model state: cycles into the current sample, samples completed in the current bit
  int m_cyc, m_samp, m_div, m_pend, m_busy, m_sclk, m_bclk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_samp = 0; m_div = DEF_DIV; m_pend = DEF_DIV;
    m_busy = 0; m_sclk = 0; m_bclk = 0;
  endtask

  task automatic model_step(input int e, input int rs, input int wr, input int din);
    exp_t x;
    int   apply;
    x.smp = 0; x.bot = 0; apply = 0;
    if (rs != 0) begin
      m_cyc = 0; m_samp = 0; apply = m_busy;
    end else if (e == 0) begin
      apply = m_busy;
    end else begin
      m_cyc = (m_cyc + 1) % 65536;
      if (m_cyc == m_div) begin
        m_cyc = 0; x.smp = 1; m_sclk = 1 - m_sclk; m_samp++;
        if (m_samp == OVS) begin
          m_samp = 0; x.bot = 1; m_bclk = 1 - m_bclk; apply = m_busy;
        end
      end
    end
    if (apply != 0) begin
      m_div = m_pend; m_busy = 0;
    end else if (wr != 0 && m_busy == 0) begin
      m_pend = (din < 2) ? 2 : din; m_busy = 1;
    end
    x.busy = m_busy; x.idx = m_samp; x.sclk = m_sclk; x.bclk = m_bclk;
    sb_q.push_back(x);
  endtask

  // called at a falling edge: drive inputs for the next rising edge and queue its outcome
  task automatic drive(input int e, input int rs, input int wr, input int din);
    en = (e != 0); resync = (rs != 0); div_wr = (wr != 0); div_in = DIV_W'(din);
    model_step(e, rs, wr, din);
    @(negedge sys_clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_smp_tick"}, smp_tick, 0);
    check({tag, "_bot_tick"}, bot_tick, 0);
    check({tag, "_smp_idx"},  smp_idx,  0);
    check({tag, "_smp_clk"},  smp_clk,  0);
    check({tag, "_bot_clk"},  bot_clk,  0);
    check({tag, "_div_busy"}, div_busy, 0);
  endtask

  task automatic async_reset();
    @(posedge sys_clk);
    #2 reset = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (2) @(negedge sys_clk);
    model_reset();
    reset = 1'b1;
  endtask

  // monitor: compare DUT outputs against the scoreboard after each rising edge
  initial begin : monitor
    exp_t x;
    int   edge_no;
    int   want;
    edge_no = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (reset) edge_no++;
      else edge_no = 0;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("smp_tick", smp_tick, x.smp);
        check("bot_tick", bot_tick, x.bot);
        check("div_busy", div_busy, x.busy);
        check("smp_idx",  smp_idx,  x.idx);
        check("smp_clk",  smp_clk,  x.sclk);
        check("bot_clk",  bot_clk,  x.bclk);
      end
      if (dir_phase && edge_no >= 1 && edge_no <= 40) begin
        want = 0;
        foreach (dir_smp_edges[i]) if (dir_smp_edges[i] == edge_no) want = 1;
        check("dir_smp_tick", smp_tick, want);
        check("dir_bot_tick", bot_tick, (edge_no == 16 || edge_no == 40) ? 1 : 0);
        check("dir_div_busy", div_busy, (edge_no >= 5 && edge_no <= 15) ? 1 : 0);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    model_reset();
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    reset     = 1'b1;
    dir_phase = 1'b1;
    for (int e = 1; e <= 44; e++) drive(1, 0, (e == 5) ? 1 : 0, 6);
    dir_phase = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1000 || c == 2200) async_reset();
      drive(($urandom_range(0, 9) != 0) ? 1 : 0,
            ($urandom_range(0, 49) == 0) ? 1 : 0,
            ($urandom_range(0, 19) == 0) ? 1 : 0,
            int'($urandom_range(0, 7)));
    end
    @(posedge sys_clk);
    #3;
    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
